// File: rtl/ram_p0_arb_pkg.sv
// Shared constants for the RAM port-0 arbiter slice.
//   STAT_W   : width of each per-requester grant counter
//   STAT_SAT : saturation value of the grant counters
//   RID_W    : width of the requester index carried with read data
package ram_p0_arb_pkg;
  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;
  localparam int unsigned RID_W = 3;
endpackage

// File: rtl/ram_p0_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports:
//   req_i      : per-requester request vector
//   last_gnt_i : index of the most recently granted requester
//   gnt_o      : one-hot grant (zero when no request)
//   idx_o      : binary index of the granted requester (0 when none)
// The search starts at (last_gnt_i+1) mod N and wraps once around.
module rr_pick
  import ram_p0_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [RID_W-1:0] last_gnt_i,
  output logic [N-1:0]     gnt_o,
  output logic [RID_W-1:0] idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_gnt_i) + k) % N;
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = RID_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_p0_arbiter.sv
// ram_p0_arbiter: round-robin sharing of RAM port 0 between NUM_REQ
// single-beat requesters. Grant is combinational; read data is registered
// and returned one cycle after the read grant together with the winner id.
// Ports:
//   clock, reset            : clock (rising edge), async active-high reset
//   req/req_we/req_addr/req_wdata : per-requester request, flattened buses
//   gnt                     : one-hot grant, same cycle as the RAM access
//   rvalid/rid/rdata        : registered read response
//   ram_port_en_0, ram_wr_en, ram_addr_p0, ram_data_in : RAM port-0 drive
//   ram_data_out_0          : RAM port-0 read data
//   stat_gnt_cnt            : saturating 16-bit grant counters per requester,
//                             present only when RAM_P0_ARB_STATS_EN is defined
module ram_p0_arbiter
  import ram_p0_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rvalid,
  output logic [RID_W-1:0]          rid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_port_en_0,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_addr_p0,
  output logic [DATA_W-1:0]         ram_data_in,
  input  logic [DATA_W-1:0]         ram_data_out_0
`ifdef RAM_P0_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_gnt_cnt
`endif
);

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [RID_W-1:0]   pick_idx;
  logic               any_gnt;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  logic [RID_W-1:0]   last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rvalid_q, rvalid_d;
  logic [RID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  // Requests are masked during reset so the combinational grant and RAM
  // drive show their reset values for as long as reset is held.
  always_comb begin
    req_eff = reset ? '0 : req;
  end

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i      (req_eff),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx)
  );

  always_comb begin
    any_gnt   = |pick_gnt;
    win_we    = req_we[pick_idx];
    win_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    win_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];

    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rvalid_d   = 1'b0;
    rid_d      = rid_q;
    rdata_d    = rdata_q;

    if (any_gnt) begin
      last_gnt_d = pick_idx;
      addr_d     = win_addr;
      wdata_d    = win_wdata;
      if (!win_we) begin
        rvalid_d = 1'b1;
        rid_d    = pick_idx;
        rdata_d  = ram_data_out_0;
      end
    end

    gnt           = pick_gnt;
    ram_port_en_0 = any_gnt;
    ram_wr_en     = any_gnt & win_we;
    // Address/data come straight from the winner, and otherwise replay the
    // last granted values so the RAM pins do not toggle while idle.
    ram_addr_p0   = addr_d;
    ram_data_in   = wdata_d;
    rvalid        = rvalid_q;
    rid           = rid_q;
    rdata         = rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_gnt_q <= RID_W'(NUM_REQ - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef RAM_P0_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (pick_gnt[i] && (cnt_q[i] != STAT_SAT)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_gnt_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) stat_gnt_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif

endmodule

// File: doc/ram_p0_arbiter.md
# ram_p0_arbiter

Round-robin arbiter that shares port 0 of the 16x8 simple dual-port RAM between NUM_REQ requesters. Each requester issues single-beat read or write requests with a req/gnt handshake. The arbiter drives the RAM port-0 enable, write enable, address and data. It returns registered read data to the winning requester one cycle after the grant. Port 1 of the RAM stays a dedicated read port and is not touched by this block.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held until granted
- req_we  in  NUM_REQ  per-requester write (1) / read (0)
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as access
- rvalid  out  1  read data valid, one cycle after a read grant
- rid  out  3  index of requester owning rdata
- rdata  out  DATA_W  registered read data
- ram_port_en_0  out  1  to RAM port_en_0
- ram_wr_en  out  1  to RAM wr_en
- ram_addr_p0  out  ADDR_W  to RAM addr_in_p0
- ram_data_in  out  DATA_W  to RAM data_in
- ram_data_out_0  in  DATA_W  from RAM data_output_0
- stat_gnt_cnt  out  NUM_REQ*16  per-requester grant counters (present only with RAM_P0_ARB_STATS_EN)

## Operation
- Arbitration is round-robin over req.
  - Search starts at index (last_gnt+1) mod NUM_REQ.
  - last_gnt resets to NUM_REQ-1, so requester 0 has top priority after reset.
- At most one gnt bit is high per cycle. gnt[i] is high only if req[i] is high.
- With any grant in a cycle:
  - ram_port_en_0=1.
  - ram_addr_p0, ram_data_in and ram_wr_en=req_we[w] are muxed from winner w.
- With no request: ram_port_en_0=0 and ram_wr_en=0. Address and data hold their last value to limit toggling.
- The RAM read output is combinational and floats (Z) when port_en_0=0. It is sampled only on a read grant.
- Read grant: at the clock edge, rdata<=ram_data_out_0, rid<=w and rvalid<=1.
- Any other cycle: rvalid<=0, and rdata and rid hold.
- Write grant: the RAM commits at the same edge. No response is returned. The requester treats gnt as completion.
- A requester may drop req or change req_we/addr/wdata only after its gnt cycle. Changing them while req is high and ungranted is illegal.
- last_gnt updates only on a grant. Idle cycles leave the pointer unchanged.

## Timing
- Reset values: gnt=0, rvalid=0, rid=0, rdata=0, ram_port_en_0=0, ram_wr_en=0, ram_addr_p0=0, ram_data_in=0, last_gnt=NUM_REQ-1, stat counters=0.
- Grant latency: 0 cycles. gnt is asserted in the first cycle req is seen, if that requester wins.
- Read latency: rvalid and rdata arrive 1 cycle after the gnt cycle.
- Sustained throughput: one access per cycle. Back-to-back reads from different requesters give rvalid high on consecutive cycles with rid changing.
- Worst-case wait for a held request: NUM_REQ-1 cycles.
- Write then read to the same address on consecutive cycles: the read returns the new data.
- Reset asserted mid-operation clears everything immediately, including a pending rvalid. That response is lost.
- A requester holding req continuously across grants is granted again only after every other active requester has been granted.

## Configuration
- RAM_P0_ARB_STATS_EN defined:
  - stat_gnt_cnt is present.
  - Each 16-bit counter increments on its requester's grant and saturates at 16'hFFFF.
  - Counters clear only on reset.
- Undefined: the stat_gnt_cnt port and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package ram_p0_arb_pkg holds:
  - the stat counter width constant (16)
  - the counter saturation value
  - the rid width constant (3)
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are req and last_gnt; outputs are a one-hot grant and a binary index.
- The top level holds the pointer, response registers, RAM muxing and optional counters.

## Test plan
- Reset: assert reset mid-transfer -> all outputs at reset values within the same cycle, and rvalid=0.
- Single write then read: req0 write addr 4'h3 data 8'hA5, then req0 read addr 4'h3 -> gnt[0] both cycles, ram_wr_en=1 then 0; next cycle rvalid=1, rid=0, rdata=8'hA5.
- Contention: req0 and req1 both read continuously from reset -> gnt sequence 01,10,01,10 (requester 0 first), rid alternating 0,1.
- Fairness with idle gap: req1 alone granted, then req0 and req1 together -> gnt[0] wins the next cycle.
- Idle: no req for 5 cycles -> ram_port_en_0=0 and ram_wr_en=0 throughout, rvalid=0, last_gnt unchanged.
- Stats (with RAM_P0_ARB_STATS_EN): 70000 grants to req0 -> stat_gnt_cnt[15:0]=16'hFFFF, and requester 1's counter unchanged.
